// File: rtl/mcl_rx_arbiter.sv
// Round-robin share of the MCL receive channel; MCL_RX_ARB_STATS_EN adds per-requester grant counters.
// Latency: 1 cycle from req_v_i to mcl_v_o; 1 beat/cycle sustained.
// Backpressure: single registered stage holds on ~mcl_r_i; launches also gated by adapter vacancy.
module mcl_rx_arbiter #(
    parameter int num_req_p         = 4,
    parameter int mcl_width_p       = 128,
    parameter int max_out_credits_p = 16,
    parameter int reserve_p         = 1,
    localparam int VW  = $clog2(max_out_credits_p + 1),
    localparam int IDW = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [num_req_p-1:0]           req_v_i,
    input  logic [num_req_p*mcl_width_p-1:0] req_data_i,
    output logic [num_req_p-1:0]           req_yumi_o,
    output logic                           mcl_v_o,
    output logic [mcl_width_p-1:0]         mcl_data_o,
    input  logic                           mcl_r_i,
    input  logic [VW-1:0]                  rcv_vacancy_i,
    output logic [IDW-1:0]                 grant_id_o,
`ifdef MCL_RX_ARB_STATS_EN
    input  logic                           stats_clear_i,
    output logic [num_req_p*32-1:0]        stats_o,
`endif
    input  logic                           flush_i,
    output logic                           flush_done_o
);

    typedef enum logic [1:0] {IDLE, SEND, DRAIN, DONE} state_t;
    typedef logic [IDW:0] sum_t;
    localparam sum_t NREQ = sum_t'(num_req_p);

    state_t                 r_state, w_state_nxt;
    logic [IDW-1:0]         r_ptr, w_ptr_nxt, w_gnt_id, r_grant_id;
    logic                   r_mcl_v;
    logic [mcl_width_p-1:0] r_mcl_data, w_gnt_data;
    logic                   w_free, w_launch_ok, w_gnt, w_found;
    logic [num_req_p-1:0]   w_yumi;
    sum_t                   w_idx, w_inc;

    assign w_free      = ~r_mcl_v | mcl_r_i;
    // A beat still sitting in the stage will consume one more slot once it leaves.
    assign w_launch_ok = 32'(rcv_vacancy_i) > (32'(reserve_p) + (r_mcl_v ? 32'd1 : 32'd0));
    assign w_gnt       = reset_n_i & (r_state == SEND) & ~flush_i & w_free & w_launch_ok & w_found;

    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_idx    = '0;
        for (int i = 0; i < num_req_p; i++) begin
            w_idx = sum_t'(r_ptr) + sum_t'(i);
            if (w_idx >= NREQ) w_idx = w_idx - NREQ;
            if (!w_found && req_v_i[w_idx[IDW-1:0]]) begin
                w_found  = 1'b1;
                w_gnt_id = w_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        w_yumi     = '0;
        w_gnt_data = '0;
        for (int k = 0; k < num_req_p; k++) begin
            w_yumi[k] = w_gnt && (w_gnt_id == IDW'(k));
            if (w_yumi[k]) w_gnt_data = req_data_i[k*mcl_width_p +: mcl_width_p];
        end
    end

    assign w_inc     = sum_t'(w_gnt_id) + sum_t'(1);
    assign w_ptr_nxt = (w_inc >= NREQ) ? '0 : w_inc[IDW-1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = SEND;
            SEND:    if (flush_i) w_state_nxt = DRAIN;
            DRAIN:   if (!r_mcl_v || mcl_r_i) w_state_nxt = DONE;
            DONE:    if (!flush_i) w_state_nxt = SEND;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_mcl_v    <= 1'b0;
            r_mcl_data <= '0;
            r_grant_id <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt) begin
                r_ptr      <= w_ptr_nxt;
                r_mcl_v    <= 1'b1;
                r_mcl_data <= w_gnt_data;
                r_grant_id <= w_gnt_id;
            end else if (mcl_r_i) begin
                r_mcl_v <= 1'b0;
            end
        end
    end

    assign req_yumi_o   = w_yumi;
    assign mcl_v_o      = r_mcl_v;
    assign mcl_data_o   = r_mcl_data;
    assign grant_id_o   = r_grant_id;
    assign flush_done_o = (r_state == DONE) & flush_i;

`ifdef MCL_RX_ARB_STATS_EN
    logic [31:0] r_stats [num_req_p];

    always_ff @(posedge clk_i) begin
        for (int k = 0; k < num_req_p; k++) begin
            if (!reset_n_i)
                r_stats[k] <= '0;
            else if (stats_clear_i)
                r_stats[k] <= w_yumi[k] ? 32'd1 : 32'd0;
            else if (w_yumi[k] && (r_stats[k] != 32'hFFFF_FFFF))
                r_stats[k] <= r_stats[k] + 32'd1;
        end
    end

    for (genvar k = 0; k < num_req_p; k++) begin : g_stats
        assign stats_o[k*32 +: 32] = r_stats[k];
    end
`endif

endmodule

// File: tb/tb_mcl_rx_arbiter.sv
// Bench for mcl_rx_arbiter: vector tables plus hand sequences, scoreboard on output beats.
module tb_mcl_rx_arbiter;
    localparam int N  = 4;
    localparam int W  = 128;
    localparam int VW = 5;
    localparam logic [W-1:0] A5 = {16{8'hA5}};

    logic           clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset_n;
    logic [N-1:0]   req_v;
    logic [W-1:0]   dat [N];
    logic [N*W-1:0] req_data;
    logic [N-1:0]   yumi;
    logic           mcl_v;
    logic [W-1:0]   mcl_data;
    logic           mcl_r;
    logic [VW-1:0]  vac;
    logic [1:0]     gid;
    logic           flush;
    logic           done;

    assign req_data = {dat[3], dat[2], dat[1], dat[0]};

    mcl_rx_arbiter dut (
        .clk_i(clk), .reset_n_i(reset_n), .req_v_i(req_v), .req_data_i(req_data),
        .req_yumi_o(yumi), .mcl_v_o(mcl_v), .mcl_data_o(mcl_data), .mcl_r_i(mcl_r),
        .rcv_vacancy_i(vac), .grant_id_o(gid), .flush_i(flush), .flush_done_o(done)
    );

    typedef struct {
        logic [N-1:0]  rv;
        logic          r;
        logic [VW-1:0] vac;
        logic          fl;
        logic [N-1:0]  y;
        logic          v;
        logic          d;
    } vec_t;

    typedef struct {
        logic [1:0]   id;
        logic [W-1:0] data;
    } exp_t;

    exp_t sbq [$];
    vec_t tbl [$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic logic [W-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    function automatic logic [1:0] oh_idx(input logic [N-1:0] oh);
        logic [1:0] r = 2'd0;
        for (int i = 0; i < N; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    function automatic vec_t mk(input logic [N-1:0] rv, input logic r, input int vac_i,
                                input logic fl, input logic [N-1:0] y, input logic v, input logic d);
        vec_t t;
        t.rv = rv; t.r = r; t.vac = VW'(vac_i); t.fl = fl; t.y = y; t.v = v; t.d = d;
        return t;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Inputs are driven just after a rising edge; outputs sampled on the falling edge.
    task automatic step(input vec_t v, input string tag);
        exp_t       e;
        logic [1:0] k;
        req_v = v.rv; mcl_r = v.r; vac = v.vac; flush = v.fl;
        k = oh_idx(v.y);
        @(negedge clk);
        if (mcl_v && mcl_r) begin
            if (sbq.size() == 0) begin
                chk(1'b0, {tag, " unexpected_beat"}, W'(gid), '0);
            end else begin
                e = sbq.pop_front();
                chk(gid == e.id, {tag, " beat_id"}, W'(gid), W'(e.id));
                chk(mcl_data == e.data, {tag, " beat_data"}, mcl_data, e.data);
            end
        end
        chk(mcl_v == v.v, {tag, " mcl_v"}, W'(mcl_v), W'(v.v));
        chk(done == v.d, {tag, " flush_done"}, W'(done), W'(v.d));
        chk(yumi == v.y, {tag, " yumi"}, W'(yumi), W'(v.y));
        if (v.y != '0) begin
            e.id   = k;
            e.data = dat[k];
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        if (v.y != '0) dat[k] = rnd();
    endtask

    task automatic run_tbl(input string pfx);
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("%s%0d", pfx, i));
        tbl.delete();
    endtask

    initial begin
        reset_n = 1'b0; req_v = '0; mcl_r = 1'b1; vac = VW'(16); flush = 1'b0;
        for (int k = 0; k < N; k++) dat[k] = rnd();
        repeat (2) @(posedge clk);
        #1;
        chk(mcl_v == 1'b0,    "rst_mcl_v", W'(mcl_v), '0);
        chk(mcl_data == '0,   "rst_data", mcl_data, '0);
        chk(gid == 2'd0,      "rst_gid", W'(gid), '0);
        chk(yumi == '0,       "rst_yumi", W'(yumi), '0);
        chk(done == 1'b0,     "rst_done", W'(done), '0);
        reset_n = 1'b1;

        // fairness, sparse requesters, credit gating
        tbl.push_back(mk(4'hF, 1, 16, 0, 4'h0, 0, 0));
        tbl.push_back(mk(4'hF, 1, 16, 0, 4'h1, 0, 0));
        tbl.push_back(mk(4'hF, 1, 16, 0, 4'h2, 1, 0));
        tbl.push_back(mk(4'hF, 1, 16, 0, 4'h4, 1, 0));
        tbl.push_back(mk(4'hF, 1, 16, 0, 4'h8, 1, 0));
        tbl.push_back(mk(4'hF, 1, 16, 0, 4'h1, 1, 0));
        tbl.push_back(mk(4'hF, 1, 16, 0, 4'h2, 1, 0));
        tbl.push_back(mk(4'hA, 1, 16, 0, 4'h8, 1, 0));
        tbl.push_back(mk(4'hA, 1, 16, 0, 4'h2, 1, 0));
        tbl.push_back(mk(4'hA, 1, 16, 0, 4'h8, 1, 0));
        tbl.push_back(mk(4'hF, 1, 16, 0, 4'h1, 1, 0));
        tbl.push_back(mk(4'hF, 0,  2, 0, 4'h0, 1, 0));
        tbl.push_back(mk(4'hF, 1,  3, 0, 4'h2, 1, 0));
        tbl.push_back(mk(4'hF, 1,  2, 0, 4'h0, 1, 0));
        tbl.push_back(mk(4'hF, 1,  1, 0, 4'h0, 0, 0));
        tbl.push_back(mk(4'hF, 1,  2, 0, 4'h4, 0, 0));
        tbl.push_back(mk(4'h0, 1, 16, 0, 4'h0, 1, 0));
        tbl.push_back(mk(4'h0, 1, 16, 0, 4'h0, 0, 0));
        run_tbl("rr");

        // backpressure hold on requester 2
        dat[2] = A5;
        step(mk(4'h4, 1, 16, 0, 4'h4, 0, 0), "bp_grant");
        for (int i = 0; i < 5; i++) begin
            step(mk(4'hF, 0, 16, 0, 4'h0, 1, 0), $sformatf("bp_hold%0d", i));
            chk(mcl_data == A5, $sformatf("bp_data%0d", i), mcl_data, A5);
            chk(gid == 2'd2, $sformatf("bp_gid%0d", i), W'(gid), W'(2));
        end
        step(mk(4'hF, 1, 16, 0, 4'h8, 1, 0), "bp_release");
        step(mk(4'h0, 1, 16, 0, 4'h0, 1, 0), "bp_drain");

        // flush with a held beat, then resume
        tbl.push_back(mk(4'hF, 0, 16, 0, 4'h1, 0, 0));
        tbl.push_back(mk(4'hF, 0, 16, 1, 4'h0, 1, 0));
        tbl.push_back(mk(4'hF, 0, 16, 1, 4'h0, 1, 0));
        tbl.push_back(mk(4'hF, 1, 16, 1, 4'h0, 1, 0));
        tbl.push_back(mk(4'hF, 1, 16, 1, 4'h0, 0, 1));
        tbl.push_back(mk(4'hF, 1, 16, 0, 4'h0, 0, 0));
        tbl.push_back(mk(4'hF, 1, 16, 0, 4'h2, 0, 0));
        tbl.push_back(mk(4'h0, 1, 16, 0, 4'h0, 1, 0));
        tbl.push_back(mk(4'hF, 1, 16, 0, 4'h4, 0, 0));
        tbl.push_back(mk(4'hF, 1, 16, 0, 4'h8, 1, 0));
        run_tbl("fl");

        // reset while requester 3's beat is staged: beat dropped, pointer back to 0
        reset_n = 1'b0; req_v = 4'hF; mcl_r = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1; mcl_r = 1'b1;
        #1;
        chk(mcl_v == 1'b0, "mid_rst_mcl_v", W'(mcl_v), '0);
        chk(yumi == '0, "mid_rst_yumi", W'(yumi), '0);
        sbq.delete();
        tbl.push_back(mk(4'hF, 1, 16, 0, 4'h0, 0, 0));
        tbl.push_back(mk(4'hF, 1, 16, 0, 4'h1, 0, 0));
        tbl.push_back(mk(4'h0, 1, 16, 0, 4'h0, 1, 0));
        tbl.push_back(mk(4'h0, 1, 16, 0, 4'h0, 0, 0));
        run_tbl("rst");

        chk(sbq.size() == 0, "sb_empty", W'(sbq.size()), '0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/mcl_rx_arbiter.md
Name: mcl_rx_arbiter

Overview:
- Shares the single CL-to-host receive channel (mcl_v/mcl_data/mcl_r) of the AXI-Lite MCL adapter among num_req_p CL-side response sources.
- Arbitration is round-robin, one mcl_width_p beat per grant, into a one-entry registered output stage.
- Launches are gated by the adapter's receive-FIFO vacancy, so the host read path never back-pressures the fabric beyond reserve_p.
- Provides a flush sequence for quiescing the channel before a host-side reset.

Parameters:
num_req_p, 4, number of requesters (2..16)
mcl_width_p, 128, packet width; must equal the adapter's mcl_width_p
max_out_credits_p, 16, adapter receive-FIFO depth; sizes rcv_vacancy_i
reserve_p, 1, vacancy slots held back and never consumed by this block

Ports:
clk_i  in  1  clock
reset_n_i  in  1  reset, synchronous, active-low
req_v_i  in  num_req_p  per-requester valid
req_data_i  in  num_req_p*mcl_width_p  requester k at bits [k*mcl_width_p +: mcl_width_p]
req_yumi_o  out  num_req_p  one-hot; requester k's beat accepted this cycle
mcl_v_o  out  1  to adapter mcl_v_i
mcl_data_o  out  mcl_width_p  to adapter mcl_data_i
mcl_r_i  in  1  from adapter mcl_r_o
rcv_vacancy_i  in  $clog2(max_out_credits_p+1)  from adapter rcv_vacancy_o
grant_id_o  out  $clog2(num_req_p)  source id of the beat in the output stage
flush_i  in  1  level; request quiesce
flush_done_o  out  1  channel idle and no grants issued

Behaviour:
- Reset (reset_n_i=0 at a clock edge): mcl_v_o=0, mcl_data_o=0, grant_id_o=0, req_yumi_o=0, flush_done_o=0, round-robin pointer=0, state=IDLE. A reset mid-transfer drops the staged beat; the requester has already been yumi'd and is not replayed.
- Output stage: one register. Beat leaves when mcl_v_o & mcl_r_i. mcl_data_o and grant_id_o hold stable while mcl_v_o=1 and mcl_r_i=0.
- Slot free this cycle: free = ~mcl_v_o | mcl_r_i.
- Credit rule: launch_ok = rcv_vacancy_i > reserve_p + (mcl_v_o ? 1 : 0). Compare at full width; no wrap. If rcv_vacancy_i <= reserve_p, never launch.
- Grant: in state SEND, when free & launch_ok & |req_v_i, select the first valid requester at or after the pointer, cyclically. Assert req_yumi_o[k] combinationally in the same cycle. Load the stage at the next edge. Pointer becomes (k+1) mod num_req_p. The pointer is unchanged when there is no grant.
- Throughput: 1 beat/cycle sustained when mcl_r_i=1 and credit is available. Latency from req_v_i to mcl_v_o is 1 cycle.
- Requesters must hold req_v_i/data until yumi; req_yumi_o is never asserted without req_v_i.
- FSM:
  - IDLE -> SEND on the first cycle after reset release.
  - SEND -> DRAIN when flush_i=1. No new grants from that cycle on, including a same-cycle flush_i and request.
  - DRAIN -> DONE when mcl_v_o=0, or when the staged beat handshakes in that cycle.
  - DONE: flush_done_o=1. DONE -> SEND when flush_i deasserts; flush_done_o=0 from that cycle.
- Simultaneous stage handshake and new grant in one cycle: both occur; mcl_v_o remains 1 with the new data.
- num_req_p=1: pointer is constant 0 and grant_id_o=0.

Optional Feature:
MCL_RX_ARB_STATS_EN
- Defined:
  - Adds output stats_o [num_req_p*32], one 32-bit grant counter per requester.
  - A counter increments on each req_yumi_o[k] and saturates at 32'hFFFF_FFFF.
  - All counters clear on reset and on stats_clear_i (extra 1-bit input). If stats_clear_i and a grant occur in the same cycle, the counter ends at 1.
- Undefined: neither port exists and no counter logic is built.

Test Plan:
- Round-robin fairness: num_req_p=4, all req_v_i=1, mcl_r_i=1, rcv_vacancy_i=16 -> grant_id_o sequence 0,1,2,3,0,1,... and one beat per cycle after a 1-cycle latency.
- Backpressure hold: grant requester 2 with data 128'hA5..A5, then mcl_r_i=0 for 5 cycles -> mcl_data_o and grant_id_o=2 stable, no further req_yumi_o, and release in the cycle mcl_r_i=1.
- Credit gating: reserve_p=1, rcv_vacancy_i=2 with the stage full -> no grant. Raise it to 3 -> exactly one grant. rcv_vacancy_i=1 with the stage empty -> no grant.
- Sparse requesters: only req 1 and req 3 valid, pointer=2 -> grant 3 then 1 then 3. Pointer after the last grant is 0.
- Flush: flush_i=1 while the stage holds a beat and mcl_r_i=0 -> no yumi, flush_done_o=0. mcl_r_i=1 -> flush_done_o=1 the next cycle. flush_i=0 -> grants resume.
- Reset mid-stream: reset_n_i=0 for 1 cycle during traffic -> next cycle mcl_v_o=0, req_yumi_o=0, and the first grant after release goes to requester 0.
